fifo_read_sched: RTL and testbench
==================================

# fifo_read_sched

Round-robin scheduler that sequences up to `CH_NUM` frame-reader channels sharing one downstream consumer. It grants one requesting channel at a time and drives that reader's `fs` start strobe. It then waits for the reader's `fd` done acknowledge and for `fd` to return low, which completes the four-phase handshake, before moving on. A per-frame watchdog converts a hung reader into a sticky error.

## Interface
- `CH_NUM`, 4: number of reader channels, 2..16.
- `CW`, 2: width of `sel`, ≥ clog2(`CH_NUM`).
- `TIMEOUT`, 16'd1000: maximum cycles allowed per handshake phase.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: permits new grants; does not abort a frame already in progress.
- `req`  in  `CH_NUM`: per-channel frame-ready request.
- `fs`  out  `CH_NUM`: per-channel start strobe; at most one bit set.
- `fd`  in  `CH_NUM`: per-channel done acknowledge from the readers.
- `sel`  out  `CW`: index of the granted channel.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a frame completes.
- `err`  out  1: sticky timeout flag.
- `err_clr`  in  1: clears `err`; honoured only in ERR.
- `frame_cnt`  out  16: count of completed frames; wraps.

## Operation
- States: IDLE, ARB, WAIT, REL, ERR. All outputs are registered.
- IDLE → ARB when `en` & |`req`.
- ARB: search `req` circularly starting at `ptr`. The first set bit is latched into `sel`. Go to WAIT.
  - If `req` is all-zero in ARB, return to IDLE without a grant.
- WAIT: `fs[sel]`=1.
  - `fd[sel]`=1 → REL.
  - `timer`==`TIMEOUT`-1 → ERR.
- REL: `fs`=0.
  - `fd[sel]`=0 → IDLE, with `done`=1, `frame_cnt`+1, `ptr`=`sel`+1.
  - `timer`==`TIMEOUT`-1 → ERR.
- ERR: `fs`=0, `err`=1, `ptr`=`sel`+1.
  - `err_clr` → IDLE; `err` clears on the same edge.
- `ptr` wraps from `CH_NUM`-1 to 0, so `CH_NUM` need not be a power of two.
- `timer`: 16 bits. Clears on entry to WAIT and on entry to REL; increments in WAIT and REL; saturates and never wraps.
- `req` changes after ARB are ignored for the current frame.
- `fd` of non-selected channels is ignored in all states.
- `en` dropping mid-frame has no effect; the frame completes normally.
- `fd[sel]` already high on entry to WAIT counts as an immediate ack: state REL on the next cycle.
- Reset values: state IDLE, `fs`=0, `sel`=0, `ptr`=0, `busy`=0, `done`=0, `err`=0, `frame_cnt`=0, `timer`=0.
- Reset mid-frame: `fs` is 0 on the cycle after the `rst` edge, with no `done` pulse. The reader is responsible for returning to idle once `fs` is low.

## Timing
- Grant latency, counting the cycle where IDLE sees `en` & `req` as cycle 0:
  - ARB at cycle 1, `sel` valid at cycle 2.
  - `fs[sel]` high from cycle 2.
- `fd[sel]` sampled high at edge k → `fs[sel]` low from cycle k+1.
- `fd[sel]` sampled low in REL at edge m → `done` high during cycle m+1 only; `frame_cnt` updated in the same cycle.
- Back-to-back throughput: next ARB no earlier than 1 cycle after `done`. The minimum frame overhead is 4 scheduler cycles plus reader time.
- Readers may drive `fd` from any edge. `fd` is sampled at posedge only and is treated as already synchronous.
- Timeout fires when the phase has lasted `TIMEOUT` cycles: ERR is entered on that edge and `err`=1 in the following cycle.

## Test plan
- Single request: `req`=4'b0100 and `en`=1. Model reader asserts `fd` 5 cycles after `fs` and releases it 1 cycle after `fs` falls. Required: `sel`=2, `fs`=4'b0100 for 6 cycles, one `done` pulse, `frame_cnt`=1.
- Fairness: `req`=4'b1111 held for 8 frames. Required grant order 0,1,2,3,0,1,2,3; never two `fs` bits set at once; `frame_cnt`=8.
- Pointer skip: `ptr`=1 (after one frame on channel 0), then `req`=4'b0001. Required: grant channel 0 after circular wrap; next `ptr`=1.
- Timeout in WAIT: `TIMEOUT`=16, `fd` held low. Required: ERR after 16 WAIT cycles, `fs`=0, `err`=1, no `done`. Then `err_clr` → IDLE, `err`=0, and the next grant goes to channel `sel`+1.
- `en` and `req` drop mid-frame: both fall during WAIT. Required: frame completes, `done` pulses, then state stays IDLE.
- Reset mid-REL: assert `rst` for 1 cycle. Required: `fs`=0, `busy`=0, `frame_cnt`=0, `ptr`=0 next cycle; no `done` pulse.

Source files
------------

// File: rtl/fifo_read_sched.sv
// Round-robin scheduler granting one frame-reader channel at a time over a four-phase
// fs/fd handshake, with a per-phase watchdog that latches a sticky error.
module fifo_read_sched #(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned CW      = 2,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH_NUM-1:0] req,
  output logic [CH_NUM-1:0] fs,
  input  logic [CH_NUM-1:0] fd,
  output logic [CW-1:0]     sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {StIdle, StArb, StWait, StRel, StErr} state_e;

  state_e              state_q, state_d;
  logic [CH_NUM-1:0]   fs_q, fs_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         timer_q, timer_d;

  logic                found;
  logic [CW-1:0]       grant;
  logic [CW-1:0]       cand;
  int unsigned         arb_idx;
  logic [CW-1:0]       sel_inc;
  logic [15:0]         timer_inc;
  logic                timer_hit;
  logic                fd_sel;

  // Circular search starting at ptr; explicit wrap keeps non-power-of-two CH_NUM correct.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    arb_idx = 0;
    cand    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      arb_idx = 32'(ptr_q) + i;
      if (arb_idx >= CH_NUM) arb_idx = arb_idx - CH_NUM;
      cand = CW'(arb_idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign sel_inc   = (sel_q == CW'(CH_NUM - 1)) ? '0 : sel_q + CW'(1);
  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
  assign timer_hit = (timer_q == TIMEOUT - 16'd1);
  assign fd_sel    = fd[sel_q];

  always_comb begin
    state_d     = state_q;
    fs_d        = '0;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    timer_d     = timer_q;
    unique case (state_q)
      StIdle: begin
        if (en && (|req)) state_d = StArb;
      end
      StArb: begin
        if (found) begin
          state_d = StWait;
          sel_d   = grant;
          fs_d    = {{(CH_NUM-1){1'b0}}, 1'b1} << grant;
          timer_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (fd_sel) begin
          state_d = StRel;
          timer_d = '0;
        end else if (timer_hit) begin
          state_d = StErr;
          err_d   = 1'b1;
          ptr_d   = sel_inc;
        end else begin
          fs_d    = fs_q;
          timer_d = timer_inc;
        end
      end
      StRel: begin
        if (!fd_sel) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          ptr_d       = sel_inc;
        end else if (timer_hit) begin
          state_d = StErr;
          err_d   = 1'b1;
          ptr_d   = sel_inc;
        end else begin
          timer_d = timer_inc;
        end
      end
      StErr: begin
        if (err_clr) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fs_q        <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      fs_q        <= fs_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      timer_q     <= timer_d;
    end
  end

  assign fs        = fs_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_read_sched.sv
// Directed bench for fifo_read_sched: grant latency, fairness, pointer wrap, timeout,
// mid-frame en/req drop and mid-frame reset.
module tb_fifo_read_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  fs;
  logic [3:0]  fd = '0;
  logic [1:0]  sel;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  fifo_read_sched #(
    .CH_NUM (4),
    .CW     (2),
    .TIMEOUT(16'd16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .fs       (fs),
    .fd       (fd),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0; fd = '0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reader model: asserts fd[ch] after seeing fs high for `hold` cycles, drops it once fs falls.
  task automatic do_frame(input logic [3:0] r, input int hold, input bit drop,
                          output int ch, output int highs, output int first_i,
                          output bit got_done, output bit onehot_ok);
    en = 1'b1; req = r;
    ch = -1; highs = 0; first_i = -1; got_done = 1'b0; onehot_ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ($countones(fs) > 1) onehot_ok = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (fs != 4'b0) begin
        highs++;
        if (highs == 1) begin
          first_i = i;
          for (int b = 0; b < 4; b++) if (fs[b]) ch = b;
          if (drop) begin en = 1'b0; req = '0; end
        end
        if (highs == hold) fd[ch[1:0]] = 1'b1;
      end else if (highs > 0) begin
        fd = '0;
      end
    end
  endtask

  int ch, highs, first_i, cnt;
  bit got_done, onehot_ok, saw;

  initial begin
    do_reset();
    check("reset_fs", fs, 0);
    check("reset_sel", sel, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_frame_cnt", frame_cnt, 0);

    // Single request on channel 2
    do_frame(4'b0100, 6, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    req = '0;
    check("single_ch", ch, 2);
    check("single_latency", first_i, 1);
    check("single_fs_cycles", highs, 6);
    check("single_done", got_done, 1);
    check("single_sel", sel, 2);
    check("single_frame_cnt", frame_cnt, 1);
    check("single_busy_at_done", busy, 0);
    @(negedge clk);
    check("single_done_pulse", done, 0);

    // Fairness over 8 frames with all channels requesting
    do_reset();
    saw = 1'b1;
    for (int f = 0; f < 8; f++) begin
      do_frame(4'b1111, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
      check($sformatf("fair_order_%0d", f), ch, f % 4);
      if (!onehot_ok || !got_done) saw = 1'b0;
    end
    req = '0;
    check("fair_onehot_done", saw, 1);
    check("fair_frame_cnt", frame_cnt, 8);

    // Pointer wrap: ptr=1 after channel 0, lone request on 0 wraps back to it
    do_reset();
    do_frame(4'b0001, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    check("skip_first", ch, 0);
    do_frame(4'b0001, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    check("skip_wrap", ch, 0);
    do_frame(4'b0011, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    req = '0;
    check("skip_next_ptr", ch, 1);

    // Timeout in WAIT with fd held low
    do_reset();
    en = 1'b1; req = 4'b0010;
    highs = 0; saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
      if (err) break;
      if (fs != 4'b0) highs++;
    end
    req = '0;
    check("to_wait_cycles", highs, 16);
    check("to_err", err, 1);
    check("to_fs", fs, 0);
    check("to_busy", busy, 1);
    check("to_no_done", saw, 0);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", err, 0);
    check("to_idle", busy, 0);
    do_frame(4'b1111, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    req = '0;
    check("to_next_grant", ch, 2);
    check("to_frame_cnt", frame_cnt, 1);

    // en and req drop during WAIT
    do_frame(4'b1000, 4, 1'b1, ch, highs, first_i, got_done, onehot_ok);
    check("drop_ch", ch, 3);
    check("drop_done", got_done, 1);
    check("drop_frame_cnt", frame_cnt, 2);
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy || fs != 4'b0) saw = 1'b1;
    end
    check("drop_stays_idle", saw, 0);

    // Reset while in REL
    do_reset();
    do_frame(4'b0010, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    check("rst_pre_frame_cnt", frame_cnt, 1);
    en = 1'b1; req = 4'b0010;
    cnt = 0;
    while (fs[1] !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    fd[1] = 1'b1;
    @(negedge clk);
    check("rst_in_rel_fs", fs, 0);
    check("rst_in_rel_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fd = '0; req = '0;
    check("rst_mid_fs", fs, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    check("rst_mid_done", done, 0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("rst_no_done", saw, 0);
    do_frame(4'b1111, 2, 1'b0, ch, highs, first_i, got_done, onehot_ok);
    req = '0;
    check("rst_ptr_zero", ch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
